// File: rtl/atm_pkg.sv
// atm_pkg: shared definitions for the multi-account ATM session controller.
//   - Opcode and status code constants
//   - Controller state enum
//   - Constant 16-entry account table (account number / PIN lookup)
package atm_pkg;

  // Command opcodes
  localparam logic [2:0] OP_LOGOUT        = 3'd0;
  localparam logic [2:0] OP_LOGIN         = 3'd1;
  localparam logic [2:0] OP_MENU          = 3'd2;
  localparam logic [2:0] OP_BALANCE       = 3'd3;
  localparam logic [2:0] OP_WITHDRAW      = 3'd4;
  localparam logic [2:0] OP_WITHDRAW_SHOW = 3'd5;
  localparam logic [2:0] OP_TRANSFER      = 3'd6;
  localparam logic [2:0] OP_DEPOSIT       = 3'd7;

  // Response status codes
  localparam logic [3:0] ST_OK           = 4'd0;
  localparam logic [3:0] ST_NO_ACCOUNT   = 4'd1;
  localparam logic [3:0] ST_BAD_PIN      = 4'd2;
  localparam logic [3:0] ST_LOCKED       = 4'd3;
  localparam logic [3:0] ST_INSUFFICIENT = 4'd4;
  localparam logic [3:0] ST_OVERFLOW     = 4'd5;
  localparam logic [3:0] ST_BAD_DEST     = 4'd6;
  localparam logic [3:0] ST_TIMEOUT      = 4'd7;
  localparam logic [3:0] ST_NO_SESSION   = 4'd8;
  localparam logic [3:0] ST_BAD_OP       = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND,
    S_MENU,
    S_XFER_FIND,
    S_RESP
  } state_e;

  // Account number of table entry i. Entries beyond the first four follow
  // a simple arithmetic pattern so the table scales to 16 accounts.
  function automatic logic [15:0] tbl_acc(input logic [3:0] i);
    logic [15:0] r;
    case (i)
      4'd0:    r = 16'd2816;
      4'd1:    r = 16'd3467;
      4'd2:    r = 16'd1334;
      4'd3:    r = 16'd3649;
      default: r = 16'd1000 + {12'd0, i};
    endcase
    return r;
  endfunction

  // PIN of table entry i.
  function automatic logic [3:0] tbl_pin(input logic [3:0] i);
    logic [3:0] r;
    case (i)
      4'd0:    r = 4'd6;
      4'd1:    r = 4'd3;
      4'd2:    r = 4'd9;
      4'd3:    r = 4'd9;
      default: r = i;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/atm_account_bank.sv
// atm_account_bank: per-account balance registers and lockout bits.
//   clk, rst        clock / asynchronous active-high reset
//   rd_a_*          read port A (session account balance)
//   rd_b_*          read port B (scan index balance + lock bit)
//   wr_a_*, wr_b_*  two write ports, used together for transfers
//   lock_set_i/idx  sets the lock bit of one account
// Reset restores every balance to INIT_BALANCE and clears all locks.
module atm_account_bank #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int IDX_W        = 2,
  parameter int BAL_W        = 11,
  parameter int INIT_BALANCE = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output logic [BAL_W-1:0] rd_a_bal_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic [BAL_W-1:0] rd_b_bal_o,
  output logic             rd_b_lock_o,
  input  logic             wr_a_en_i,
  input  logic [IDX_W-1:0] wr_a_idx_i,
  input  logic [BAL_W-1:0] wr_a_bal_i,
  input  logic             wr_b_en_i,
  input  logic [IDX_W-1:0] wr_b_idx_i,
  input  logic [BAL_W-1:0] wr_b_bal_i,
  input  logic             lock_set_i,
  input  logic [IDX_W-1:0] lock_idx_i
);

  logic [BAL_W-1:0]        bal_q [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) bal_q[i] <= BAL_W'(INIT_BALANCE);
      lock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        // The controller never targets the same account on both ports.
        if (wr_b_en_i && wr_b_idx_i == IDX_W'(i))
          bal_q[i] <= wr_b_bal_i;
        else if (wr_a_en_i && wr_a_idx_i == IDX_W'(i))
          bal_q[i] <= wr_a_bal_i;
        if (lock_set_i && lock_idx_i == IDX_W'(i))
          lock_q[i] <= 1'b1;
      end
    end
  end

  assign rd_a_bal_o  = bal_q[rd_a_idx_i];
  assign rd_b_bal_o  = bal_q[rd_b_idx_i];
  assign rd_b_lock_o = lock_q[rd_b_idx_i];

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: multi-account ATM session controller.
//   clk, rst                     clock / asynchronous active-high reset
//   cmd_valid, cmd_ready         command handshake (cmd_ready registered)
//   cmd_op, acc_number, pin,     command opcode and operands, captured
//   dest_acc_number, amount      on the accept edge
//   rsp_valid, rsp_status        one-cycle response pulse and status code
//   balance                      displayed balance of the session account
//   initial_balance/final_balance  destination balance before/after the
//                                last successful TRANSFER
//   session_active               an account is logged in
// LOGIN and TRANSFER scan the account table one entry per cycle. Other
// commands spend one execute cycle (pending_q) and then respond.
module atm_session_ctrl import atm_pkg::*; #(
  parameter int NUM_ACCOUNTS   = 4,
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4,
  parameter int BAL_W          = 11,
  parameter int INIT_BALANCE   = 500,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int MAX_PIN_TRIES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [ACC_W-1:0] acc_number,
  input  logic [PIN_W-1:0] pin,
  input  logic [ACC_W-1:0] dest_acc_number,
  input  logic [BAL_W-1:0] amount,
  output logic             rsp_valid,
  output logic [3:0]       rsp_status,
  output logic [BAL_W-1:0] balance,
  output logic [BAL_W-1:0] initial_balance,
  output logic [BAL_W-1:0] final_balance,
  output logic             session_active
);

  localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ACCOUNTS - 1);
  // Loaded with N-1 so that exactly TIMEOUT_CYCLES idle MENU cycles elapse.
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic [2:0]       op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d, dest_q, dest_d;
  logic [PIN_W-1:0] pin_q, pin_d;
  logic [BAL_W-1:0] amount_q, amount_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sess_open_q, sess_open_d;
  logic [IDX_W-1:0] sess_idx_q, sess_idx_d;
  logic [TRY_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_status_q, rsp_status_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;
  logic [BAL_W-1:0] init_q, init_d, final_q, final_d;

  // Account bank interface
  logic [BAL_W-1:0] src_bal, scan_bal;
  logic             scan_lock;
  logic             wr_a_en, wr_b_en, lock_set;
  logic [BAL_W-1:0] wr_a_bal, wr_b_bal;

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS),
    .IDX_W       (IDX_W),
    .BAL_W       (BAL_W),
    .INIT_BALANCE(INIT_BALANCE)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .rd_a_idx_i (sess_idx_q),
    .rd_a_bal_o (src_bal),
    .rd_b_idx_i (idx_q),
    .rd_b_bal_o (scan_bal),
    .rd_b_lock_o(scan_lock),
    .wr_a_en_i  (wr_a_en),
    .wr_a_idx_i (sess_idx_q),
    .wr_a_bal_i (wr_a_bal),
    .wr_b_en_i  (wr_b_en),
    .wr_b_idx_i (idx_q),
    .wr_b_bal_i (wr_b_bal),
    .lock_set_i (lock_set),
    .lock_idx_i (idx_q)
  );

  logic             accept;
  logic [ACC_W-1:0] tbl_acc_cur;
  logic [PIN_W-1:0] tbl_pin_cur;
  logic [BAL_W:0]   dep_sum, xfer_sum;
  logic [BAL_W-1:0] src_minus;
  logic [TRY_W-1:0] fail_next;

  assign accept      = cmd_valid && ready_q;
  assign tbl_acc_cur = ACC_W'(tbl_acc(4'(idx_q)));
  assign tbl_pin_cur = PIN_W'(tbl_pin(4'(idx_q)));
  // One extra bit catches overflow beyond 2^BAL_W-1.
  assign dep_sum     = {1'b0, src_bal} + {1'b0, amount_q};
  assign xfer_sum    = {1'b0, scan_bal} + {1'b0, amount_q};
  assign src_minus   = src_bal - amount_q;
  // Consecutive failures only accumulate against the same account.
  assign fail_next   = (fail_cnt_q != '0 && fail_idx_q == idx_q)
                       ? fail_cnt_q + TRY_W'(1) : TRY_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      ready_q      <= 1'b0;
      op_q         <= '0;
      acc_q        <= '0;
      dest_q       <= '0;
      pin_q        <= '0;
      amount_q     <= '0;
      idx_q        <= '0;
      sess_open_q  <= 1'b0;
      sess_idx_q   <= '0;
      fail_cnt_q   <= '0;
      fail_idx_q   <= '0;
      tmr_q        <= TMR_RELOAD;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      bal_out_q    <= '0;
      init_q       <= '0;
      final_q      <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      dest_q       <= dest_d;
      pin_q        <= pin_d;
      amount_q     <= amount_d;
      idx_q        <= idx_d;
      sess_open_q  <= sess_open_d;
      sess_idx_q   <= sess_idx_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_idx_q   <= fail_idx_d;
      tmr_q        <= tmr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      bal_out_q    <= bal_out_d;
      init_q       <= init_d;
      final_q      <= final_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    op_d         = op_q;
    acc_d        = acc_q;
    dest_d       = dest_q;
    pin_d        = pin_q;
    amount_d     = amount_q;
    idx_d        = idx_q;
    sess_open_d  = sess_open_q;
    sess_idx_d   = sess_idx_q;
    fail_cnt_d   = fail_cnt_q;
    fail_idx_d   = fail_idx_q;
    tmr_d        = tmr_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    bal_out_d    = bal_out_q;
    init_d       = init_q;
    final_d      = final_q;
    wr_a_en      = 1'b0;
    wr_a_bal     = src_minus;
    wr_b_en      = 1'b0;
    wr_b_bal     = xfer_sum[BAL_W-1:0];
    lock_set     = 1'b0;

    // Operand capture on every accept; the command also reloads the timer.
    if (accept) begin
      op_d     = cmd_op;
      acc_d    = acc_number;
      pin_d    = pin;
      dest_d   = dest_acc_number;
      amount_d = amount;
      tmr_d    = TMR_RELOAD;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          pending_d    = 1'b0;
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = (op_q == OP_LOGOUT || op_q == OP_MENU) ? ST_OK : ST_NO_SESSION;
        end else if (accept) begin
          if (cmd_op == OP_LOGIN) begin
            state_d = S_FIND;
            idx_d   = '0;
          end else begin
            pending_d = 1'b1;
          end
        end
      end

      S_MENU: begin
        if (pending_q) begin
          pending_d    = 1'b0;
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          case (op_q)
            OP_LOGOUT:  sess_open_d = 1'b0;
            OP_MENU:    ;
            OP_BALANCE: bal_out_d = src_bal;
            OP_WITHDRAW, OP_WITHDRAW_SHOW: begin
              if (amount_q > src_bal) begin
                rsp_status_d = ST_INSUFFICIENT;
              end else begin
                wr_a_en = 1'b1;
                if (op_q == OP_WITHDRAW_SHOW) bal_out_d = src_minus;
              end
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W]) begin
                rsp_status_d = ST_OVERFLOW;
              end else begin
                wr_a_en   = 1'b1;
                wr_a_bal  = dep_sum[BAL_W-1:0];
                bal_out_d = dep_sum[BAL_W-1:0];
              end
            end
            default: rsp_status_d = ST_BAD_OP; // LOGIN inside a session
          endcase
        end else if (accept) begin
          if (cmd_op == OP_TRANSFER) begin
            state_d = S_XFER_FIND;
            idx_d   = '0;
          end else begin
            pending_d = 1'b1;
          end
        end else if (tmr_q == '0) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          sess_open_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_FIND: begin
        if (acc_q == tbl_acc_cur) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          if (scan_lock) begin
            rsp_status_d = ST_LOCKED;
          end else if (pin_q == tbl_pin_cur) begin
            rsp_status_d = ST_OK;
            sess_open_d  = 1'b1;
            sess_idx_d   = idx_q;
            fail_cnt_d   = '0;
          end else begin
            rsp_status_d = ST_BAD_PIN;
            fail_cnt_d   = fail_next;
            fail_idx_d   = idx_q;
            lock_set     = (fail_next >= TRY_W'(MAX_PIN_TRIES));
          end
        end else if (idx_q == LAST_IDX) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_NO_ACCOUNT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_XFER_FIND: begin
        if (dest_q == tbl_acc_cur) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          if (idx_q == sess_idx_q) begin
            rsp_status_d = ST_BAD_DEST;
          end else if (amount_q > src_bal) begin
            rsp_status_d = ST_INSUFFICIENT;
          end else if (xfer_sum[BAL_W]) begin
            rsp_status_d = ST_OVERFLOW;
          end else begin
            rsp_status_d = ST_OK;
            wr_a_en      = 1'b1;
            wr_b_en      = 1'b1;
            init_d       = scan_bal;
            final_d      = xfer_sum[BAL_W-1:0];
            bal_out_d    = src_minus;
          end
        end else if (idx_q == LAST_IDX) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_BAD_DEST;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_RESP: begin
        if (sess_open_q) begin
          state_d = S_MENU;
          tmr_d   = TMR_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Registered ready: high whenever the next state can take a new command.
  assign ready_d = (state_d == S_IDLE || state_d == S_MENU) && !pending_d;

  assign cmd_ready       = ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_status      = rsp_status_q;
  assign balance         = bal_out_q;
  assign initial_balance = init_q;
  assign final_balance   = final_q;
  assign session_active  = sess_open_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
module tb_atm_session_ctrl;

  localparam int ACC_W = 12;
  localparam int PIN_W = 4;
  localparam int BAL_W = 11;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [ACC_W-1:0] acc_number = '0;
  logic [PIN_W-1:0] pin = '0;
  logic [ACC_W-1:0] dest_acc_number = '0;
  logic [BAL_W-1:0] amount = '0;
  logic             rsp_valid;
  logic [3:0]       rsp_status;
  logic [BAL_W-1:0] balance, initial_balance, final_balance;
  logic             session_active;

  atm_session_ctrl #(
    .NUM_ACCOUNTS(4), .ACC_W(ACC_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .INIT_BALANCE(500), .TIMEOUT_CYCLES(TMO), .MAX_PIN_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .acc_number(acc_number), .pin(pin),
    .dest_acc_number(dest_acc_number), .amount(amount),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .balance(balance),
    .initial_balance(initial_balance), .final_balance(final_balance),
    .session_active(session_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       do_rst;
    logic [2:0] op;
    int         acc, pn, dest, amt;
    int         st, bal, ini, fin;
    logic       sess;
    int         lat;
  } vec_t;

  typedef struct {
    int   st, bal, ini, fin;
    logic sess;
    int   lat;
    int   cyc;
    int   id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_rsp_cyc = 0;

  task automatic check(input string name, input int id, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0d expected %0d", name, id, act, req);
    end
  endtask

  // Scoreboard: every response pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got status %0d with no pending command", rsp_status);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_rsp_cyc = cyc;
        $display("txn %0d: status=%0d bal=%0d init=%0d final=%0d sess=%0d lat=%0d",
                 e.id, rsp_status, balance, initial_balance, final_balance,
                 session_active, cyc - e.cyc);
        check("status",  e.id, int'(rsp_status), e.st);
        check("balance", e.id, int'(balance), e.bal);
        check("initial", e.id, int'(initial_balance), e.ini);
        check("final",   e.id, int'(final_balance), e.fin);
        check("session", e.id, int'(session_active), int'(e.sess));
        if (e.lat != 0) check("latency", e.id, cyc - e.cyc, e.lat);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no response after %0d cycles, expected one", budget);
      sb.delete();
    end
  endtask

  task automatic send(input logic [2:0] op, input int acc, input int pn, input int dest,
                      input int amt, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait (txn %0d): got cmd_ready 0 expected 1", e.id);
      return;
    end
    cmd_op = op;
    acc_number = ACC_W'(acc);
    pin = PIN_W'(pn);
    dest_acc_number = ACC_W'(dest);
    amount = BAL_W'(amt);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    sb.push_back(e);
    cmd_valid = 1'b0;
    wait_drain(20);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic v(input logic r, input int op, input int acc, input int pn, input int dest,
                   input int amt, input int st, input int bal, input int ini, input int fin,
                   input logic sess, input int lat);
    vec_t x;
    x.do_rst = r; x.op = 3'(op); x.acc = acc; x.pn = pn; x.dest = dest; x.amt = amt;
    x.st = st; x.bal = bal; x.ini = ini; x.fin = fin; x.sess = sess; x.lat = lat;
    vecs.push_back(x);
  endtask

  function automatic exp_t mk(input int st, input int bal, input int ini, input int fin,
                              input logic sess, input int lat, input int id);
    exp_t e;
    e.st = st; e.bal = bal; e.ini = ini; e.fin = fin; e.sess = sess; e.lat = lat;
    e.cyc = 0; e.id = id;
    return e;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // ops: 0 LOGOUT 1 LOGIN 2 MENU 3 BAL 4 WD 5 WDS 6 XFER 7 DEP
    // status: 0 OK 1 NOACC 2 BADPIN 3 LOCKED 4 INSUF 5 OVF 6 BADDEST 7 TMO 8 NOSESS 9 BADOP
    v(0,1,3467,3,0,0,    0,0,0,0,1,2);
    v(0,3,0,0,0,0,       0,500,0,0,1,1);
    v(0,1,2816,6,0,0,    9,500,0,0,1,1);
    v(0,0,0,0,0,0,       0,500,0,0,0,1);
    v(0,3,0,0,0,0,       8,500,0,0,0,1);
    v(0,2,0,0,0,0,       0,500,0,0,0,1);
    v(0,1,1234,0,0,0,    1,500,0,0,0,4);
    v(0,1,2816,6,0,0,    0,500,0,0,1,1);
    v(0,7,0,0,0,1600,    5,500,0,0,1,1);
    v(0,5,0,0,0,62,      0,438,0,0,1,1);
    v(0,4,0,0,0,505,     4,438,0,0,1,1);
    v(0,4,0,0,0,38,      0,438,0,0,1,1);
    v(0,3,0,0,0,0,       0,400,0,0,1,1);
    v(0,7,0,0,0,1647,    0,2047,0,0,1,1);
    v(0,7,0,0,0,1,       5,2047,0,0,1,1);
    v(0,5,0,0,0,2047,    0,0,0,0,1,1);
    v(0,2,0,0,0,0,       0,0,0,0,1,1);
    v(0,0,0,0,0,0,       0,0,0,0,0,1);
    v(1,0,0,0,0,0,       0,0,0,0,0,0);
    v(0,1,2816,6,0,0,    0,0,0,0,1,1);
    v(0,6,0,0,3467,99,   0,401,500,599,1,2);
    v(0,6,0,0,1234,5,    6,401,500,599,1,4);
    v(0,6,0,0,2816,5,    6,401,500,599,1,1);
    v(0,6,0,0,3649,402,  4,401,500,599,1,4);
    v(0,6,0,0,1334,401,  0,0,500,901,1,3);
    v(0,0,0,0,0,0,       0,0,500,901,0,1);
    v(0,1,1334,9,0,0,    0,0,500,901,1,3);
    v(0,3,0,0,0,0,       0,901,500,901,1,1);
    v(0,7,0,0,0,1146,    0,2047,500,901,1,1);
    v(0,6,0,0,3467,1449, 5,2047,500,901,1,2);
    v(0,6,0,0,3467,1448, 0,599,599,2047,1,2);
    v(0,0,0,0,0,0,       0,599,599,2047,0,1);
    v(0,1,3649,1,0,0,    2,599,599,2047,0,4);
    v(0,1,3649,1,0,0,    2,599,599,2047,0,4);
    v(0,1,3467,0,0,0,    2,599,599,2047,0,2);
    v(0,1,3649,1,0,0,    2,599,599,2047,0,4);
    v(0,1,3649,1,0,0,    2,599,599,2047,0,4);
    v(0,1,3649,1,0,0,    2,599,599,2047,0,4);
    v(0,1,3649,9,0,0,    3,599,599,2047,0,4);
    v(0,1,3467,3,0,0,    0,599,599,2047,1,2);
    v(0,3,0,0,0,0,       0,2047,599,2047,1,1);
    v(0,0,0,0,0,0,       0,2047,599,2047,0,1);

    // Reset values, then cmd_ready on the first edge after release.
    @(negedge clk);
    check("rst_cmd_ready", 0, int'(cmd_ready), 0);
    check("rst_rsp_valid", 0, int'(rsp_valid), 0);
    check("rst_rsp_status", 0, int'(rsp_status), 0);
    check("rst_balance", 0, int'(balance), 0);
    check("rst_initial", 0, int'(initial_balance), 0);
    check("rst_final", 0, int'(final_balance), 0);
    check("rst_session", 0, int'(session_active), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", 0, int'(cmd_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        do_reset();
      end else begin
        send(vecs[i].op, vecs[i].acc, vecs[i].pn, vecs[i].dest, vecs[i].amt,
             mk(vecs[i].st, vecs[i].bal, vecs[i].ini, vecs[i].fin, vecs[i].sess,
                vecs[i].lat, i));
      end
    end

    // Inactivity timeout in MENU.
    do_reset();
    send(3'd1, 3467, 3, 0, 0, mk(0, 0, 0, 0, 1, 2, 100));
    t0 = cyc;
    sb.push_back(mk(7, 0, 0, 0, 0, 0, 101));
    wait_drain(TMO + 40);
    check("timeout_window", 101,
          int'((last_rsp_cyc - t0) >= TMO && (last_rsp_cyc - t0) <= TMO + 2), 1);
    send(3'd3, 0, 0, 0, 0, mk(8, 0, 0, 0, 0, 1, 102));

    // Reset while scanning for a transfer destination.
    do_reset();
    send(3'd1, 2816, 6, 0, 0, mk(0, 0, 0, 0, 1, 1, 110));
    @(negedge clk);
    check("xfer_ready", 111, int'(cmd_ready), 1);
    cmd_op = 3'd6;
    dest_acc_number = ACC_W'(3649);
    amount = BAL_W'(99);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_session", 111, int'(session_active), 0);
    check("abort_ready", 111, int'(cmd_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 111, int'(rsp_valid), 0);
    end
    rst = 1'b0;
    // Lock on 3649 from earlier must be gone, and no balance moved.
    send(3'd1, 3649, 9, 0, 0, mk(0, 0, 0, 0, 1, 4, 112));
    send(3'd3, 0, 0, 0, 0, mk(0, 500, 0, 0, 1, 1, 113));
    send(3'd0, 0, 0, 0, 0, mk(0, 500, 0, 0, 0, 1, 114));
    send(3'd1, 2816, 6, 0, 0, mk(0, 500, 0, 0, 1, 1, 115));
    send(3'd3, 0, 0, 0, 0, mk(0, 500, 0, 0, 1, 1, 116));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
